i2s_rx: RTL and testbench



---
 rtl/i2s_rx.sv | 135 +++++++++++++
 tb/tb_i2s_rx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples the asynchronous I2S pins in the clk domain,
// recovers BCK rises and assembles MSB-aligned stereo samples with framing checks.
module i2s_rx #(
  parameter int SAMPLE_BITS = 24,
  parameter int MIN_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i2s_lrck,
  input  logic                   i2s_bck,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   sample_valid,
  output logic                   frame_error
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] bck_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   bck_prev_q;
  logic                   rise_q;
  logic                   lrck_r_q;
  logic                   data_r_q;
  logic                   lrck_prev_q;
  logic [5:0]             cnt_q;
  logic [5:0]             cnt_d;
  logic [SAMPLE_BITS-1:0] word_q;
  logic [SAMPLE_BITS-1:0] word_d;
  logic [SAMPLE_BITS-1:0] left_hold_q;
  logic                   left_short_q;
  logic [SAMPLE_BITS-1:0] left_data_q;
  logic [SAMPLE_BITS-1:0] right_data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   word_end;
  logic                   cnt_short;

  // Current word with this rise's bit merged in; bits past SAMPLE_BITS match no position.
  always_comb begin
    word_d = word_q;
    for (int unsigned i = 0; i < SAMPLE_BITS; i++) begin
      if (int'(cnt_q) + int'(i) == SAMPLE_BITS - 1) word_d[i] = data_r_q;
    end
    cnt_d     = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    cnt_short = int'(cnt_d) < MIN_BITS;
    word_end  = lrck_r_q != lrck_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      lrck_sync_q  <= '0;
      bck_sync_q   <= '0;
      data_sync_q  <= '0;
      bck_prev_q   <= 1'b0;
      rise_q       <= 1'b0;
      lrck_r_q     <= 1'b0;
      data_r_q     <= 1'b0;
      lrck_prev_q  <= 1'b0;
      cnt_q        <= '0;
      word_q       <= '0;
      left_hold_q  <= '0;
      left_short_q <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      lrck_sync_q <= SYNC_STAGES'({lrck_sync_q, i2s_lrck});
      bck_sync_q  <= SYNC_STAGES'({bck_sync_q, i2s_bck});
      data_sync_q <= SYNC_STAGES'({data_sync_q, i2s_data});
      bck_prev_q  <= bck_sync_q[SYNC_STAGES-1];
      // Edge strobe is registered together with the LRCK/DATA samples taken at the same instant.
      rise_q      <= bck_sync_q[SYNC_STAGES-1] & ~bck_prev_q;
      lrck_r_q    <= lrck_sync_q[SYNC_STAGES-1];
      data_r_q    <= data_sync_q[SYNC_STAGES-1];
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      if (rise_q) begin
        lrck_prev_q <= lrck_r_q;
        case (state_q)
          ST_SYNC: begin
            if (lrck_prev_q && !lrck_r_q) begin
              state_q <= ST_LEFT;
              cnt_q   <= '0;
              word_q  <= '0;
            end
          end
          ST_LEFT: begin
            if (word_end) begin
              left_hold_q  <= word_d;
              left_short_q <= cnt_short;
              cnt_q        <= '0;
              word_q       <= '0;
              state_q      <= ST_RIGHT;
            end else begin
              cnt_q  <= cnt_d;
              word_q <= word_d;
            end
          end
          ST_RIGHT: begin
            if (word_end) begin
              left_data_q  <= left_hold_q;
              right_data_q <= word_d;
              valid_q      <= 1'b1;
              ferr_q       <= left_short_q | cnt_short;
              cnt_q        <= '0;
              word_q       <= '0;
              state_q      <= ST_LEFT;
            end else begin
              cnt_q  <= cnt_d;
              word_q <= word_d;
            end
          end
          default: state_q <= ST_SYNC;
        endcase
      end
    end
  end

  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign sample_valid = valid_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds I2S bit streams from channel words, drives the pins
// and checks captured strobes against a word-level model of the framing rules.
module tb_i2s_rx;
  localparam int SB = 24;
  localparam int MB = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2s_lrck = 1'b0;
  logic          i2s_bck = 1'b0;
  logic          i2s_data = 1'b0;
  logic [SB-1:0] left_data;
  logic [SB-1:0] right_data;
  logic          sample_valid;
  logic          frame_error;

  int checks = 0;
  int errors = 0;
  int clk_cnt = 0;
  int hold_viol = 0;

  typedef struct packed {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
    logic          e;
    logic [31:0]   edge_n;
  } strobe_t;

  bit      chan_q[$];
  bit      data_q[$];
  int      rise_cnt[0:4095];
  strobe_t got_q[$];
  strobe_t exp_q[$];

  i2s_rx #(.SAMPLE_BITS(SB), .MIN_BITS(MB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .i2s_lrck(i2s_lrck), .i2s_bck(i2s_bck), .i2s_data(i2s_data),
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt++;

  logic [SB-1:0] prev_l = '0;
  logic [SB-1:0] prev_r = '0;
  logic          prev_v = 1'b0;
  always @(negedge clk) begin
    if (sample_valid === 1'b1) got_q.push_back('{left_data, right_data, frame_error, clk_cnt});
    if (!rst && sample_valid !== 1'b1 && (left_data !== prev_l || right_data !== prev_r)) hold_viol++;
    if (frame_error === 1'b1 && sample_valid !== 1'b1) hold_viol++;
    if (sample_valid === 1'b1 && prev_v === 1'b1) hold_viol++;
    prev_l = left_data;
    prev_r = right_data;
    prev_v = sample_valid;
  end

  // One channel slot of `slot` bit periods: nbits of val MSB first, then zeros.
  function automatic void add_word(bit ch, logic [63:0] val, int nbits, int slot);
    for (int i = 0; i < slot; i++) begin
      chan_q.push_back(ch);
      data_q.push_back(i < nbits ? val[nbits-1-i] : 1'b0);
    end
  endfunction

  function automatic void new_stream();
    chan_q.delete();
    data_q.delete();
    got_q.delete();
    exp_q.delete();
  endfunction

  function automatic logic [SB-1:0] word_of(int s, int e);
    logic [SB-1:0] w = '0;
    for (int i = 0; i < SB && s + i <= e; i++) w[SB-1-i] = data_q[s+i];
    return w;
  endfunction

  // Word-level model: split bits into channel runs; after the first right run that
  // ends (with a prior rise since reset), each complete left+right pair is one strobe.
  function automatic void build_expected(int from);
    int rs[$];
    int re[$];
    bit rc[$];
    int s = from;
    int n = chan_q.size();
    exp_q.delete();
    for (int p = from; p < n; p++) begin
      if (p == n - 1 || chan_q[p+1] != chan_q[p]) begin
        rs.push_back(s); re.push_back(p); rc.push_back(chan_q[p]);
        s = p + 1;
      end
    end
    for (int i = 0; i < rs.size(); i++) begin
      if (rc[i] == 1'b1 && re[i] >= from + 1 && i + 1 < rs.size()) begin
        for (int j = i + 1; j + 2 < rs.size(); j += 2) begin
          strobe_t t;
          t.l = word_of(rs[j], re[j]);
          t.r = word_of(rs[j+1], re[j+1]);
          t.e = (re[j] - rs[j] + 1 < MB) || (re[j+1] - rs[j+1] + 1 < MB);
          t.edge_n = rise_cnt[re[j+1]] + SS + 2;
          exp_q.push_back(t);
        end
        break;
      end
    end
  endfunction

  // LRCK leads data by one bit period, so period p shows the channel of bit p+1.
  task automatic drive_bits(int from, int upto, int h);
    for (int p = from; p < upto; p++) begin
      i2s_lrck = (p + 1 < chan_q.size()) ? chan_q[p+1] : chan_q[p];
      i2s_data = data_q[p];
      #(h * 10);
      i2s_bck = 1'b1;
      rise_cnt[p] = clk_cnt;
      #(h * 10);
      i2s_bck = 1'b0;
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic start_phase(int ph);
    @(negedge clk);
    #(ph);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    i2s_bck = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
  endtask

  function automatic int rand_phase();
    int ph = $urandom_range(0, 8);
    return (ph >= 5) ? ph + 1 : ph;
  endfunction

  task automatic test_reset();
    int k;
    reset_dut();
    checks++;
    if ({left_data, right_data, sample_valid, frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_state got l=%h r=%h v=%b e=%b want all 0", left_data, right_data, sample_valid, frame_error);
    end
    new_stream();
    add_word(1'b1, 64'h0, 0, 20);
    for (int f = 0; f < 3; f++) begin
      add_word(1'b0, 64'($urandom), 24, 32);
      add_word(1'b1, 64'($urandom), 24, 32);
    end
    add_word(1'b0, 64'h0, 0, 4);
    k = 124;  // inside the second frame's right word
    start_phase(3);
    drive_bits(0, k, 2);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL reset_prefix_strobes got %0d want 1", got_q.size());
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({left_data, right_data, sample_valid, frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_midframe got l=%h r=%h v=%b e=%b want all 0", left_data, right_data, sample_valid, frame_error);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    start_phase(7);
    drive_bits(k, chan_q.size(), 2);
    build_expected(k);
    checks++;
    if (got_q.size() !== exp_q.size() || exp_q.size() !== 1) begin
      errors++;
      $display("FAIL reset_resume_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_resume[%0d] got l=%h r=%h e=%b edge=%0d want l=%h r=%h e=%b edge=%0d", i,
                 got_q[i].l, got_q[i].r, got_q[i].e, got_q[i].edge_n, exp_q[i].l, exp_q[i].r, exp_q[i].e, exp_q[i].edge_n);
      end
    end
  endtask

  task automatic test_stereo24();
    reset_dut();
    new_stream();
    add_word(1'b1, 64'h0, 0, 8);
    for (int f = 0; f < 3; f++) begin
      add_word(1'b0, 64'h123456, 24, 32);
      add_word(1'b1, 64'hABCDEF, 24, 32);
    end
    add_word(1'b0, 64'h0, 0, 4);
    start_phase(rand_phase());
    drive_bits(0, chan_q.size(), $urandom_range(2, 4));
    build_expected(0);
    checks++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== 3) begin
      errors++;
      $display("FAIL stereo24_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i].l !== 24'h123456 || got_q[i].r !== 24'hABCDEF || got_q[i].e !== 1'b0 ||
          (i < exp_q.size() && got_q[i].edge_n !== exp_q[i].edge_n)) begin
        errors++;
        $display("FAIL stereo24[%0d] got l=%h r=%h e=%b edge=%0d want l=123456 r=abcdef e=0 edge=%0d", i,
                 got_q[i].l, got_q[i].r, got_q[i].e, got_q[i].edge_n, (i < exp_q.size()) ? exp_q[i].edge_n : -1);
      end
    end
  endtask

  task automatic test_16bit();
    reset_dut();
    new_stream();
    add_word(1'b1, 64'h0, 0, 3);
    for (int f = 0; f < 2; f++) begin
      add_word(1'b0, 64'h8001, 16, 16);
      add_word(1'b1, 64'h7FFF, 16, 16);
    end
    add_word(1'b0, 64'h0, 0, 2);
    start_phase(rand_phase());
    drive_bits(0, chan_q.size(), 2);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL w16_count got %0d want 2", got_q.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i].l !== 24'h800100 || got_q[i].r !== 24'h7FFF00 || got_q[i].e !== 1'b0) begin
        errors++;
        $display("FAIL w16[%0d] got l=%h r=%h e=%b want l=800100 r=7fff00 e=0", i, got_q[i].l, got_q[i].r, got_q[i].e);
      end
    end
  endtask

  task automatic test_mid_right_phase_sweep();
    for (int ph = 0; ph < 10; ph++) begin
      if (ph == 5) continue;
      reset_dut();
      new_stream();
      add_word(1'b0, 64'($urandom), 24, 6);   // tail of a left word
      add_word(1'b1, 64'($urandom), 24, 13);  // partial right word
      for (int f = 0; f < 2; f++) begin
        add_word(1'b0, 64'($urandom), 24, 32);
        add_word(1'b1, 64'($urandom), 24, 32);
      end
      add_word(1'b0, 64'h0, 0, 3);
      start_phase(ph);
      drive_bits(0, chan_q.size(), 2);
      build_expected(0);
      checks++;
      if (got_q.size() !== exp_q.size() || exp_q.size() !== 2) begin
        errors++;
        $display("FAIL midright_ph%0d_count got %0d want %0d", ph, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL midright_ph%0d[%0d] got l=%h r=%h e=%b edge=%0d want l=%h r=%h e=%b edge=%0d", ph, i,
                   got_q[i].l, got_q[i].r, got_q[i].e, got_q[i].edge_n, exp_q[i].l, exp_q[i].r, exp_q[i].e, exp_q[i].edge_n);
        end
      end
    end
  endtask

  task automatic test_short_word();
    reset_dut();
    new_stream();
    add_word(1'b1, 64'h0, 0, 5);
    add_word(1'b0, 64'hABC, 12, 12);
    add_word(1'b1, 64'h5A5A5A, 24, 32);
    add_word(1'b0, 64'h111111, 24, 32);
    add_word(1'b1, 64'h222222, 24, 32);
    add_word(1'b0, 64'h0, 0, 2);
    start_phase(rand_phase());
    drive_bits(0, chan_q.size(), 3);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL short_count got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].l !== 24'hABC000 || got_q[0].r !== 24'h5A5A5A || got_q[0].e !== 1'b1) begin
        errors++;
        $display("FAIL short_frame got l=%h r=%h e=%b want l=abc000 r=5a5a5a e=1", got_q[0].l, got_q[0].r, got_q[0].e);
      end
      checks++;
      if (got_q[1].l !== 24'h111111 || got_q[1].r !== 24'h222222 || got_q[1].e !== 1'b0) begin
        errors++;
        $display("FAIL short_next got l=%h r=%h e=%b want l=111111 r=222222 e=0", got_q[1].l, got_q[1].r, got_q[1].e);
      end
    end
  endtask

  task automatic test_long_word();
    reset_dut();
    new_stream();
    add_word(1'b1, 64'h0, 0, 4);
    add_word(1'b0, 64'h0F0F0F, 24, 24);
    add_word(1'b1, {24'h0, 24'hC0FFEE, 16'($urandom)}, 40, 40);
    add_word(1'b0, 64'h0, 0, 2);
    start_phase(rand_phase());
    drive_bits(0, chan_q.size(), 2);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL long_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].l !== 24'h0F0F0F || got_q[0].r !== 24'hC0FFEE || got_q[0].e !== 1'b0) begin
        errors++;
        $display("FAIL long_frame got l=%h r=%h e=%b want l=0f0f0f r=c0ffee e=0", got_q[0].l, got_q[0].r, got_q[0].e);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 5; it++) begin
      int h = $urandom_range(2, 4);
      int nf = $urandom_range(2, 4);
      reset_dut();
      new_stream();
      add_word(1'b1, {$urandom, $urandom}, 40, $urandom_range(1, 40));
      for (int f = 0; f < nf; f++) begin
        for (int c = 0; c < 2; c++) begin
          int nb = (f == 1) ? 1 : $urandom_range(1, 48);
          add_word(c[0], {$urandom, $urandom}, nb, nb + $urandom_range(0, 4));
        end
      end
      add_word(1'b0, 64'h0, 0, 2);
      start_phase(rand_phase());
      drive_bits(0, chan_q.size(), h);
      build_expected(0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_count got %0d want %0d", it, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d[%0d] got l=%h r=%h e=%b edge=%0d want l=%h r=%h e=%b edge=%0d", it, i,
                   got_q[i].l, got_q[i].r, got_q[i].e, got_q[i].edge_n, exp_q[i].l, exp_q[i].r, exp_q[i].e, exp_q[i].edge_n);
        end
      end
    end
  endtask

  task automatic test_output_stability();
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL output_stability got %0d violations want 0", hold_viol);
    end
  endtask

  initial begin
    test_reset();
    test_stereo24();
    test_16bit();
    test_mid_right_phase_sweep();
    test_short_word();
    test_long_word();
    test_random_frames();
    test_output_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
